imem_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the single-cycle MIPS core's instruction memory. Accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit words, writes them sequentially into instruction memory from address 0, and holds the program counter cleared until the image is complete. Once loading ends it releases the core for execution, or parks in an error state if the image is malformed.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_loader_word_packer.sv | 45 ++++
 rtl/imem_loader.sv | 152 +++++++++++++++
 tb/tb_imem_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {StHdr, StLoad, StCsum, StRun, StErr} state_e;

  localparam int unsigned BYTES_PER_WORD = 4;

  // Header code that stands for a full-capacity image.
  localparam logic [7:0] HDR_MAX_CODE = 8'h00;

  function automatic logic [31:0] hdr_words(input logic [7:0] hdr, input int unsigned addr_w);
    return (hdr == HDR_MAX_CODE) ? (32'd1 << addr_w) : {24'd0, hdr};
  endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs an accepted byte stream little-endian into words; flags the final lane.
module word_packer
  import imem_loader_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              clear_i,
  input  logic              byte_en_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_done_o
);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [1:0]        lane_q, lane_d;

  always_comb begin
    shift_d = shift_q;
    lane_d  = lane_q;
    if (clear_i) begin
      shift_d = '0;
      lane_d  = '0;
    end else if (byte_en_i) begin
      shift_d = {byte_i, shift_q[DATA_W-1:8]};
      lane_d  = 2'(lane_q + 2'd1);
    end
  end

  // Newest byte lands in the top lane, so the word is complete on the last lane.
  assign word_o      = {byte_i, shift_q[DATA_W-1:8]};
  assign word_done_o = byte_en_i && !clear_i && (lane_q == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      shift_q <= '0;
      lane_q  <= '0;
    end else begin
      shift_q <= shift_d;
      lane_q  <= lane_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header + byte payload -> sequential imem writes, then release the core.
// Optional trailing checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              pc_clr,
  output logic              cpu_run,
  output logic              load_err
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [31:0] Cap  = 32'd1 << ADDR_W;

  state_e            state_q, state_d;
  logic [CntW-1:0]   n_q, n_d;
  logic [CntW-1:0]   wcnt_q, wcnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept, pk_clear, pk_en, pk_done;
  logic [DATA_W-1:0] pk_word;
  logic [31:0]       hdr_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  assign accept = byte_valid && byte_ready;
  assign hdr_n  = hdr_words(byte_data, ADDR_W);

  word_packer #(.DATA_W(DATA_W)) u_packer (
    .clk        (clk),
    .clr_n      (clr_n),
    .clear_i    (pk_clear),
    .byte_en_i  (pk_en),
    .byte_i     (byte_data),
    .word_o     (pk_word),
    .word_done_o(pk_done)
  );

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    wcnt_d     = wcnt_q;
    byte_ready = 1'b0;
    pk_clear   = 1'b0;
    pk_en      = 1'b0;
    pc_clr     = 1'b1;
    cpu_run    = 1'b0;
    load_err   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    unique case (state_q)
      StHdr: begin
        // Ready is withheld while reset is held, even though the state reads HDR.
        byte_ready = clr_n;
        if (accept) begin
          pk_clear = 1'b1;
          wcnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d   = byte_data;
`endif
          if (hdr_n > Cap) begin
            state_d = StErr;
          end else begin
            n_d     = hdr_n[CntW-1:0];
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        byte_ready = clr_n;
        pk_en      = accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept) csum_d = csum_q ^ byte_data;
`endif
        if (pk_done) begin
          wcnt_d = CntW'(wcnt_q + 1'b1);
          if (CntW'(wcnt_q + 1'b1) == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = StCsum;
`else
            state_d = StRun;
`endif
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCsum: begin
        byte_ready = clr_n;
        if (accept) state_d = (byte_data == csum_q) ? StRun : StErr;
      end
`endif
      StRun: begin
        pc_clr  = 1'b0;
        cpu_run = 1'b1;
      end
      StErr: begin
        load_err = 1'b1;
      end
      default: begin
        state_d = StErr;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= StHdr;
      n_q     <= '0;
      wcnt_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wcnt_q  <= wcnt_d;
      we_q    <= pk_done;
      if (pk_done) begin
        addr_q  <= wcnt_q[ADDR_W-1:0];
        wdata_q <= pk_word;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

  // The header bound makes a wrap impossible; one firing means the counter logic is broken.
  assert property (@(posedge clk) disable iff (!clr_n) pk_done |-> (32'(wcnt_q) < Cap))
    else $error("imem_loader: write address wrapped");

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: fixed vectors, table-driven images and random images.
module tb_imem_loader;

  localparam int unsigned AW  = 6;
  localparam int unsigned Cap = 64;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit Cs = 1'b1;
`else
  localparam bit Cs = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clr_n;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          pc_clr;
  logic          cpu_run;
  logic          load_err;

  imem_loader #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .pc_clr    (pc_clr),
    .cpu_run   (cpu_run),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic [7:0] hdr;
    int         gap;
    bit         corrupt;
    bit         exp_run;
    bit         exp_err;
  } vec_t;

  int          n_checks = 0;
  int          n_errs   = 0;
  wr_t         exp_q[$];
  logic [31:0] mem[Cap];
  logic [7:0]  img[256];
  logic        prev_we = 1'b0;
  vec_t        vecs[7];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Write monitor: every imem_we must match the next expected write, one cycle wide.
  always @(negedge clk) begin
    wr_t e;
    if (imem_we === 1'b1) begin
      chk("we_width", 64'(prev_we), 64'd0);
      mem[imem_addr] = imem_wdata;
      chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(imem_addr), 64'(e.addr));
        chk("wr_data", 64'(imem_wdata), 64'(e.data));
      end
    end
    prev_we = imem_we;
  end

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      byte_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic do_reset();
    clr_n      = 1'b0;
    byte_valid = 1'b0;
    #2;
    chk("rst_outputs", 64'({byte_ready, imem_we, imem_addr, imem_wdata, pc_clr, cpu_run, load_err}),
        64'({1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0}));
    @(posedge clk);
    #1;
    exp_q.delete();
    clr_n = 1'b1;
    #1;
    chk("rdy_after_rst", 64'(byte_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Reference model: header rule, little-endian packing and checksum computed from the image.
  task automatic load_image(input logic [7:0] hdr, input int gap, input bit rnd, input bit corrupt,
                            input bit auto_exp, output bit run, output bit err);
    int         n;
    logic [7:0] cs;
    wr_t        w;
    n   = (hdr == 8'h00) ? Cap : int'(hdr);
    err = n > Cap;
    run = !err && !(Cs && corrupt);
    if (auto_exp && !err) begin
      for (int i = 0; i < n; i++) begin
        w.addr = AW'(i);
        w.data = {img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]};
        exp_q.push_back(w);
      end
    end
    cs = hdr;
    send(hdr, rnd ? $urandom_range(0, gap) : gap);
    if (err) begin
      chk("err_next_cycle", 64'({load_err, byte_ready, pc_clr}), 64'(3'b101));
      for (int i = 0; i < 8; i++) send(img[i], 0);
    end else begin
      for (int i = 0; i < 4 * n; i++) begin
        send(img[i], rnd ? $urandom_range(0, gap) : gap);
        cs = cs ^ img[i];
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(corrupt ? (cs ^ 8'h5A) : cs, 0);
      chk("csum_result", 64'({imem_we, cpu_run, load_err, pc_clr}), 64'({1'b0, run, !run, !run}));
`else
      chk("run_with_last_we", 64'({imem_we, cpu_run, pc_clr}), 64'(3'b110));
`endif
    end
    send(8'hA5, 0);
    send(8'h5A, 1);
    @(posedge clk);
    #1;
    chk("final_state", 64'({cpu_run, pc_clr, load_err, byte_ready}), 64'({run, !run, !run, 1'b0}));
    chk("writes_done", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic set_fixed_image();
    logic [7:0] fixed[8];
    fixed = '{8'h20, 8'h00, 8'h01, 8'h8C, 8'h04, 8'h00, 8'h02, 8'h8C};
    for (int i = 0; i < 8; i++) img[i] = fixed[i];
  endtask

  task automatic push_fixed(input int words);
    wr_t w;
    w.addr = 6'd0; w.data = 32'h8C010020; exp_q.push_back(w);
    if (words > 1) begin
      w.addr = 6'd1; w.data = 32'h8C020004; exp_q.push_back(w);
    end
  endtask

  initial begin
    bit run, err;
    clr_n      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    for (int i = 0; i < Cap; i++) mem[i] = 32'd0;

    vecs[0] = '{8'h01, 0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h40, 0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h41, 0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h03, 2, 1'b1, !Cs, Cs};
    vecs[6] = '{8'h05, 1, 1'b0, 1'b1, 1'b0};

    // Known program, continuous and with valid toggling every other cycle.
    do_reset();
    set_fixed_image();
    push_fixed(2);
    load_image(8'h02, 0, 1'b0, 1'b0, 1'b0, run, err);
    chk("fixed_mem1", 64'(mem[1]), 64'h8C020004);
    do_reset();
    push_fixed(2);
    load_image(8'h02, 1, 1'b0, 1'b0, 1'b0, run, err);
    chk("toggle_mem0", 64'(mem[0]), 64'h8C010020);

    // Table-driven headers, including the 0 => full capacity case and oversize headers.
    foreach (vecs[k]) begin
      do_reset();
      foreach (img[i]) img[i] = 8'($urandom);
      load_image(vecs[k].hdr, vecs[k].gap, 1'b0, vecs[k].corrupt, 1'b1, run, err);
      chk("tbl_outcome", 64'({cpu_run, load_err}), 64'({vecs[k].exp_run, vecs[k].exp_err}));
    end

    // Reset after 6 of 8 payload bytes: asynchronous return, written word kept, reload works.
    do_reset();
    for (int i = 0; i < Cap; i++) mem[i] = 32'd0;
    set_fixed_image();
    push_fixed(1);
    send(8'h02, 0);
    for (int i = 0; i < 6; i++) send(img[i], 0);
    chk("pre_rst_wdata", 64'(imem_wdata), 64'h8C010020);
    do_reset();
    chk("mem0_kept", 64'(mem[0]), 64'h8C010020);
    img[0] = 8'hEF; img[1] = 8'hBE; img[2] = 8'hAD; img[3] = 8'hDE;
    load_image(8'h01, 0, 1'b0, 1'b0, 1'b1, run, err);
    chk("reload_mem0", 64'(mem[0]), 64'hDEADBEEF);

    // Random images with random gaps and headers, occasionally corrupt checksums.
    for (int it = 0; it < 6; it++) begin
      do_reset();
      foreach (img[i]) img[i] = 8'($urandom);
      load_image(8'($urandom_range(0, 70)), 2, 1'b1, ($urandom_range(0, 3) == 0), 1'b1, run, err);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
